nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that streams two WIDTH-bit operands, one nibble per clock, through a single `carry_look_ahead_adder_4bit` slice. It registers the slice's carry-out between nibbles and assembles the full sum. It sits directly upstream of the 4-bit slice, driving its a/b/Cin and consuming its sum/carry4. It trades latency for area when datapaths wider than 4 bits need only one adder instance.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_cla.sv | 29 ++
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial adder.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of 4-bit nibbles needed to cover a WIDTH-bit operand.
    function automatic int unsigned nibbles(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// Purely combinational 4-bit carry-look-ahead adder slice.
module carry_look_ahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       carry4
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Generate/propagate terms and flattened look-ahead carries.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
        sum    = p ^ c[3:0];
        carry4 = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks the operands one nibble per clock through a
// single 4-bit look-ahead slice, carrying between nibbles in a register.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N  = nibbles(WIDTH);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Reject widths that do not split into whole nibbles.
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
    end

    state_e state;
    state_e next_state;

    logic [N-1:0][NIBBLE_W-1:0] opa;
    logic [N-1:0][NIBBLE_W-1:0] opb;
    logic [N-1:0][NIBBLE_W-1:0] sum_q;
    logic [KW-1:0]              k;
    logic                       creg;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_c4;
    logic                accept;
    logic                last;

    // A start is taken whenever no add is in flight (IDLE or DONE).
    assign accept = start && (state != RUN);
    assign last   = (k == K_LAST);
    assign sum    = sum_q;

    carry_look_ahead_adder_4bit u_slice (
        .a      (opa[k]),
        .b      (opb[k]),
        .Cin    (creg),
        .sum    (nib_sum),
        .carry4 (nib_c4)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE chains straight into RUN on a new start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status flags registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
        end
    end

    // Operand capture, per-nibble accumulation and final flag update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            sum_q    <= '0;
            k        <= '0;
            creg     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            sum_q <= '0;
            k     <= '0;
            creg  <= Cin;
        end else if (state == RUN) begin
            sum_q[k] <= nib_sum;
            creg     <= nib_c4;
            if (last) begin
                carry    <= nib_c4;
                overflow <= (opa[N-1][NIBBLE_W-1] == opb[N-1][NIBBLE_W-1])
                         && (nib_sum[NIBBLE_W-1] != opa[N-1][NIBBLE_W-1]);
            end else begin
                k <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH = 16, 4 and 32.
module tb_nibble_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        st     [3];
    logic [31:0] av     [3];
    logic [31:0] bv     [3];
    logic        ci     [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        car_o  [3];
    logic        ovf_o  [3];
    logic [15:0] s16;
    logic [3:0]  s4;
    logic [31:0] s32;

    int cyc    = 0;
    int errs   = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][15:0]), .b(bv[0][15:0]),
        .Cin(ci[0]), .busy(busy_o[0]), .done(done_o[0]), .sum(s16),
        .carry(car_o[0]), .overflow(ovf_o[0])
    );

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
        .Cin(ci[1]), .busy(busy_o[1]), .done(done_o[1]), .sum(s4),
        .carry(car_o[1]), .overflow(ovf_o[1])
    );

    nibble_serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(st[2]), .a(av[2]), .b(bv[2]),
        .Cin(ci[2]), .busy(busy_o[2]), .done(done_o[2]), .sum(s32),
        .carry(car_o[2]), .overflow(ovf_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wof(input int i);
        return (i == 0) ? 16 : (i == 1) ? 4 : 32;
    endfunction

    function automatic logic [63:0] sum_of(input int i);
        case (i)
            0:       return {48'd0, s16};
            1:       return {60'd0, s4};
            default: return {32'd0, s32};
        endcase
    endfunction

    // Reference: integer addition plus a signed range test for overflow.
    function automatic exp_t model(input int w, input logic [31:0] a_,
                                   input logic [31:0] b_, input logic c_);
        exp_t r;
        longint unsigned m, ua, ub, full;
        longint half, sa, sb, s;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a_} & m;
        ub   = {32'd0, b_} & m;
        full = ua + ub + {63'd0, c_};
        r.sum   = 32'(full & m);
        r.carry = ((full >> w) & 64'd1) != 64'd0;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        s    = sa + sb + longint'({63'd0, c_});
        r.ovf = (s >= half) || (s < -half);
        r.cyc = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize();
        return q0.size() + q1.size() + q2.size();
    endfunction

    // Drive one start for a cycle; record the expectation if it was accepted.
    task automatic issue(input int i, input logic [31:0] a_, input logic [31:0] b_,
                         input logic c_, output bit acc);
        exp_t e;
        @(negedge clk);
        st[i] = 1'b1;
        av[i] = a_;
        bv[i] = b_;
        ci[i] = c_;
        acc = !busy_o[i];
        if (acc) begin
            e     = model(wof(i), a_, b_, c_);
            e.cyc = cyc + wof(i) / 4 + 1;
            push(i, e);
        end
        @(posedge clk);
        #1;
        st[i] = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (qsize() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (qsize() != 0) begin
            chk("drain_timeout", 64'(qsize()), 64'd0);
            q0.delete();
            q1.delete();
            q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep(input int i, input int count);
        int n = 0;
        int tries = 0;
        bit acc;
        logic [31:0] ra, rb;
        while (n < count && tries < 4000) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7, 0) == 0) ra = '1;
            if ($urandom_range(7, 0) == 0) rb = 32'h8000_0000 >> (32 - wof(i));
            issue(i, ra, rb, 1'($urandom_range(1, 0)), acc);
            tries++;
            if (acc) n++;
            if ($urandom_range(3, 0) == 0) @(negedge clk);
        end
        chk("sweep_accepts", 64'(n), 64'(count));
    endtask

    // Compare every done pulse against the oldest pending expectation.
    task automatic mon(input int i);
        exp_t e;
        int sz;
        if (done_o[i] === 1'b1) begin
            sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
                chk($sformatf("unexpected_done%0d", i), 64'd1, 64'd0);
            end else begin
                case (i)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("sum%0d", i), sum_of(i), {32'd0, e.sum});
                chk($sformatf("carry%0d", i), {63'd0, car_o[i]}, {63'd0, e.carry});
                chk($sformatf("ovf%0d", i), {63'd0, ovf_o[i]}, {63'd0, e.ovf});
                chk($sformatf("latency%0d", i), 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
            mon(2);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nb;
        int nacc;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
            ci[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy_o[0]}, 64'd0);
        chk("rst_done", {63'd0, done_o[0]}, 64'd0);
        chk("rst_sum", sum_of(0), 64'd0);
        chk("rst_carry", {63'd0, car_o[0]}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_o[0]}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic add with busy-width measurement.
        issue(0, 32'h1234, 32'h4321, 1'b0, acc);
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            nb += int'(busy_o[0]);
        end
        chk("busy_cycles", 64'(nb), 64'd4);
        @(negedge clk);
        chk("sum_hold_idle", sum_of(0), 64'h5555);

        // Full ripple; sum must clear on acceptance.
        issue(0, 32'hFFFF, 32'h0001, 1'b0, acc);
        @(negedge clk);
        chk("sum_clear_on_start", sum_of(0), 64'd0);
        wait_idle(50);

        // Overflow cases; carry from the previous add holds during RUN.
        issue(0, 32'h7FFF, 32'h0000, 1'b1, acc);
        @(negedge clk);
        chk("carry_hold_run", {63'd0, car_o[0]}, 64'd1);
        wait_idle(50);
        issue(0, 32'h8000, 32'h8000, 1'b0, acc);
        wait_idle(50);

        // Starts during RUN are ignored.
        issue(0, 32'hA5A5, 32'h0F0F, 1'b1, acc);
        issue(0, 32'h1111, 32'h2222, 1'b0, acc);
        chk("ignored_start_a", {63'd0, acc}, 64'd0);
        issue(0, 32'h3333, 32'h4444, 1'b1, acc);
        chk("ignored_start_b", {63'd0, acc}, 64'd0);
        wait_idle(50);

        // start held high across DONE chains a second add.
        nacc = 0;
        for (int j = 0; j < 6; j++) begin
            issue(0, $urandom, $urandom, 1'($urandom_range(1, 0)), acc);
            nacc += int'(acc);
        end
        chk("chain_accepts", 64'(nacc), 64'd2);
        wait_idle(50);

        // Leave nonzero flags, then reset in the second RUN cycle.
        issue(0, 32'h8000, 32'h8000, 1'b0, acc);
        wait_idle(50);
        issue(0, 32'h1111, 32'h1111, 1'b0, acc);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy_o[0]}, 64'd0);
        chk("arst_done", {63'd0, done_o[0]}, 64'd0);
        chk("arst_sum", sum_of(0), 64'd0);
        chk("arst_carry", {63'd0, car_o[0]}, 64'd0);
        chk("arst_ovf", {63'd0, ovf_o[0]}, 64'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 32'h0F0F, 32'h00F1, 1'b1, acc);
        wait_idle(50);

        // Random sweeps on all three widths in parallel.
        fork
            sweep(0, 20);
            sweep(1, 40);
            sweep(2, 40);
        join
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
